mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq_pkg.sv | 19 +
 rtl/mul_seq_if.sv | 29 ++
 rtl/mul_seq_alu.sv | 30 +++
 rtl/mul_seq.sv | 179 +++++++++++++++++
 tb/tb_mul_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_seq_pkg;

  localparam int MUL_ITERS = 32;

  localparam logic [5:0] ALU_ADDCC = 6'h10;
  localparam logic [5:0] ALU_SUB   = 6'h04;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIXA = 3'd2,
    FIXB = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle for mul_seq: operands and mode in, product and flags out.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the multiplier is idle (busy low).
// Ports: start/signed_op/set_cc/a/b driven by master; busy/done/prod_hi/prod_lo/N/Z/V/C by slave.
interface mul_seq_if;
  logic        start;
  logic        signed_op;
  logic        set_cc;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        N;
  logic        Z;
  logic        V;
  logic        C;

  modport master (
    output start, signed_op, set_cc, a, b,
    input  busy, done, prod_hi, prod_lo, N, Z, V, C
  );

  modport slave (
    input  start, signed_op, set_cc, a, b,
    output busy, done, prod_hi, prod_lo, N, Z, V, C
  );
endinterface

// File: rtl/mul_seq_alu.sv
// 32-bit add/subtract unit shared by every arithmetic step of the multiplier.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; cin carry/borrow in; op selects ADDcc or SUB; y result; c carry (add) or borrow (sub).
module mul_seq_alu
  import mul_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic [5:0]  op,
  output logic [31:0] y,
  output logic        c
);

  logic [32:0] res;

  always_comb begin
    res = {1'b0, a};
    case (op)
      ALU_ADDCC: res = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      // Bit 32 of the 33-bit difference is the borrow out.
      ALU_SUB:   res = {1'b0, a} - {1'b0, b} - {32'b0, cin};
      default:   res = {1'b0, a};
    endcase
    y = res[31:0];
    c = res[32];
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 -> 64 multiplier (UMUL/SMUL, optional cc update), one shift-add step per cycle.
// Latency: done pulses ITERS+3 cycles after the start-sampling edge (RUN x ITERS, FIXA, FIXB, DONE).
// Backpressure: start is ignored while busy; a new start is accepted in the IDLE cycle right after DONE.
// Ports: clk, rst_n (async active-low); bus = mul_seq_if.slave (operands/mode in, product/flags out).
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int ITERS = MUL_ITERS
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sgn_q, sgn_d;
  logic               setcc_q, setcc_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        low_q, low_d;
  // One-hot iteration counter: bit k set during RUN iteration k, so no incrementer is needed.
  logic [ITERS-1:0]   iter_q, iter_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic               v_q, v_d;
  logic               c_q, c_d;

  logic [31:0]        alu_b;
  logic [5:0]         alu_op;
  logic [31:0]        alu_y;
  logic               alu_c;
  logic [31:0]        sum;
  logic               carry;

  mul_seq_alu u_alu (
    .a   (acc_q),
    .b   (alu_b),
    .cin (1'b0),
    .op  (alu_op),
    .y   (alu_y),
    .c   (alu_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    setcc_d = setcc_q;
    acc_d   = acc_q;
    low_d   = low_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    c_d     = c_q;
    alu_b   = a_q;
    alu_op  = ALU_ADDCC;
    sum     = acc_q;
    carry   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.signed_op;
          setcc_d = bus.set_cc;
          acc_d   = '0;
          low_d   = bus.b;
          iter_d  = {{(ITERS-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end

      RUN: begin
        alu_b  = a_q;
        alu_op = ALU_ADDCC;
        if (low_q[0]) begin
          sum   = alu_y;
          carry = alu_c;
        end
        // {carry,sum,low} >> 1 -> {acc,low}
        acc_d  = {carry, sum[31:1]};
        low_d  = {sum[0], low_q[31:1]};
        iter_d = iter_q << 1;
        if (iter_q[ITERS-1]) begin
          state_d = FIXA;
        end
      end

      // Signed correction: the unsigned product of two's-complement operands
      // overshoots the high word by b when a<0 and by a when b<0.
      FIXA: begin
        alu_b  = b_q;
        alu_op = ALU_SUB;
        if (sgn_q && a_q[31]) begin
          acc_d = alu_y;
        end
        state_d = FIXB;
      end

      FIXB: begin
        alu_b  = a_q;
        alu_op = ALU_SUB;
        if (sgn_q && b_q[31]) begin
          acc_d = alu_y;
        end
        // low is final after RUN, so the flags can be taken now and land with DONE.
        if (setcc_q) begin
          n_d = low_q[31];
          z_d = (low_q == 32'd0);
          v_d = 1'b0;
          c_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      setcc_q <= 1'b0;
      acc_q   <= '0;
      low_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      setcc_q <= setcc_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      c_q     <= c_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.prod_hi = acc_q;
  assign bus.prod_lo = low_q;
  assign bus.N       = n_q;
  assign bus.Z       = z_q;
  assign bus.V       = v_q;
  assign bus.C       = c_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a cycle-level reference model plus literal product checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_seq;

  logic clk;
  logic rst_n;

  mul_seq_if bus_if ();

  mul_seq #(.ITERS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Reference model: cycles remaining in the current operation (0 = idle,
  // 1 = the done cycle), the product/flags the outputs must show when idle or done.
  int          m_left  = 0;
  logic [63:0] m_prod  = '0;
  logic [63:0] m_next  = '0;
  logic        m_cc    = 1'b0;
  logic [3:0]  m_flags = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_prod  = '0;
      m_flags = '0;
    end else if (m_left == 0) begin
      if (bus_if.start) begin
        m_left = 35;
        m_next = ref_mul(bus_if.signed_op, bus_if.a, bus_if.b);
        m_cc   = bus_if.set_cc;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_prod = m_next;
        if (m_cc) m_flags = {m_next[31], (m_next[31:0] == 32'd0), 2'b00};
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {63'd0, bus_if.busy}, {63'd0, (m_left != 0)});
    check("done", {63'd0, bus_if.done}, {63'd0, (m_left == 1)});
    if (m_left <= 1) begin
      check("prod", {bus_if.prod_hi, bus_if.prod_lo}, m_prod);
    end
    check("nzvc", {60'd0, bus_if.N, bus_if.Z, bus_if.V, bus_if.C}, {60'd0, m_flags});
  end

  // Issue one operation and wait for done; optionally pokes a second start
  // (operands 7 x 7) during RUN cycle `poke`.
  task automatic run_op(input logic s, input logic cc, input logic [31:0] x, input logic [31:0] y,
                        input int poke,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [3:0] f, output int lat);
    @(posedge clk);
    #1;
    bus_if.start     = 1'b1;
    bus_if.signed_op = s;
    bus_if.set_cc    = cc;
    bus_if.a         = x;
    bus_if.b         = y;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (lat == poke + 1 && poke > 0) bus_if.start = 1'b0;
      if (bus_if.done) break;
      if (lat >= 100) begin
        check("done_timeout", 64'(lat), 64'd35);
        break;
      end
      if (lat == poke) begin
        bus_if.start     = 1'b1;
        bus_if.signed_op = ~s;
        bus_if.set_cc    = ~cc;
        bus_if.a         = 32'd7;
        bus_if.b         = 32'd7;
      end
      lat++;
    end
    hi = bus_if.prod_hi;
    lo = bus_if.prod_lo;
    f  = {bus_if.N, bus_if.Z, bus_if.V, bus_if.C};
  endtask

  initial begin
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  f;
    int          lat;

    rst_n            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.signed_op = 1'b0;
    bus_if.set_cc    = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("rst_prod", {bus_if.prod_hi, bus_if.prod_lo}, 64'd0);
    rst_n = 1'b1;

    // UMULcc 6 x 7
    run_op(1'b0, 1'b1, 32'd6, 32'd7, 0, hi, lo, f, lat);
    check("umulcc_6x7_lat", 64'(lat), 64'd35);
    check("umulcc_6x7_prod", {hi, lo}, 64'd42);
    check("umulcc_6x7_nzvc", {60'd0, f}, 64'h0);

    // UMUL all-ones, back-to-back start; flags hold
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, f, lat);
    check("umul_ff_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("umul_ff_lat", 64'(lat), 64'd35);

    // SMULcc -3 x 5
    run_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, hi, lo, f, lat);
    check("smulcc_m3x5_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("smulcc_m3x5_nzvc", {60'd0, f}, 64'h8);

    // SMUL -1 x -1, N must hold at 1
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, f, lat);
    check("smul_m1xm1_prod", {hi, lo}, 64'd1);
    check("smul_m1xm1_nzvc_hold", {60'd0, f}, 64'h8);

    // UMULcc 0x10000 squared -> Z
    run_op(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 0, hi, lo, f, lat);
    check("umulcc_2p32_prod", {hi, lo}, 64'h0000_0001_0000_0000);
    check("umulcc_2p32_nzvc", {60'd0, f}, 64'h4);

    // start during RUN cycle 10 is ignored
    run_op(1'b0, 1'b0, 32'd1000, 32'd1000, 10, hi, lo, f, lat);
    check("ignore_start_prod", {hi, lo}, 64'd1_000_000);
    check("ignore_start_lat", 64'(lat), 64'd35);
    check("ignore_start_nzvc", {60'd0, f}, 64'h4);

    // async reset during RUN cycle 20
    @(posedge clk);
    #1;
    bus_if.start     = 1'b1;
    bus_if.signed_op = 1'b0;
    bus_if.set_cc    = 1'b1;
    bus_if.a         = 32'hFFFF_FFFF;
    bus_if.b         = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("midrun_rst_done", {63'd0, bus_if.done}, 64'd0);
    check("midrun_rst_prod", {bus_if.prod_hi, bus_if.prod_lo}, 64'd0);
    check("midrun_rst_nzvc", {60'd0, bus_if.N, bus_if.Z, bus_if.V, bus_if.C}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first operation after reset: SMULcc 0x80000000 x 2 = -2^32
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'd2, 0, hi, lo, f, lat);
    check("post_rst_prod", {hi, lo}, 64'hFFFF_FFFF_0000_0000);
    check("post_rst_lat", 64'(lat), 64'd35);
    check("post_rst_nzvc", {60'd0, f}, 64'h4);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
